// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, instruction field positions and decode payload.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD        = 4'd0,
    ALU_SUB        = 4'd1,
    ALU_EVEN_UPPER = 4'd2,
    ALU_EVEN_LOWER = 4'd3,
    ALU_GTE        = 4'd4,
    ALU_LTZ        = 4'd5,
    ALU_EZ         = 4'd6,
    ALU_EQ         = 4'd7,
    ALU_NE         = 4'd8
  } alu_op_e;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;

  localparam logic [3:0] OPC_ADDI = 4'h9;
  localparam logic [3:0] OPC_NOP  = 4'hA;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        is_cmp;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_skid.sv
// Two-entry (main + skid) output buffer with a registered ready and synchronous flush.
module decode_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_out_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ready
);

  logic [W-1:0] r_main, r_skid;
  logic         r_main_v, r_skid_v, r_ready;
  logic         w_adv, w_skid_v_nxt;

  // main advances when it transfers or is empty
  assign w_adv        = (r_main_v & i_out_ready) | ~r_main_v;
  assign w_skid_v_nxt = w_adv ? (r_skid_v & i_push) : (r_skid_v | i_push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b0;
    end else if (i_flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_adv) begin
        if (r_skid_v) begin
          r_main   <= r_skid;
          r_main_v <= 1'b1;
          if (i_push) r_skid <= i_data;
        end else begin
          r_main_v <= i_push;
          if (i_push) r_main <= i_data;
        end
      end else if (i_push) begin
        r_skid <= i_data;
      end
      r_skid_v <= w_skid_v_nxt;
      r_ready  <= ~w_skid_v_nxt;
    end
  end

  assign o_valid = r_main_v;
  assign o_data  = r_main;
  assign o_ready = r_ready;

endmodule

// File: rtl/alu_op_decoder.sv
// Instruction decoder feeding the ALU through a two-entry skid buffer.
// Optional macro DECODE_PARITY_OPS_EN enables opcodes 2/3 (evenUpper/evenLower).
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [3:0]  rd_addr,
  output logic [15:0] imm,
  output logic        use_imm,
  output logic        reg_write,
  output logic        is_cmp,
  output logic        illegal,
  input  logic        flush,
  output logic [7:0]  illegal_cnt
);

  logic [3:0] w_opc;
  dec_t       w_dec, w_out;
  logic       w_push, w_ready;
  logic [7:0] r_illegal_cnt;

  assign w_opc = instr[OPC_LSB +: FIELD_W];

  always_comb begin
    w_dec        = '0;
    w_dec.alu_op = ALU_ADD;
    w_dec.rd     = instr[RD_LSB +: FIELD_W];
    w_dec.rs     = instr[RS_LSB +: FIELD_W];
    w_dec.rt     = instr[RT_LSB +: FIELD_W];
    case (w_opc)
`ifdef DECODE_PARITY_OPS_EN
      4'h0, 4'h1, 4'h2, 4'h3: begin
`else
      4'h0, 4'h1: begin
`endif
        w_dec.alu_op    = alu_op_e'(w_opc);
        w_dec.reg_write = 1'b1;
      end
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
        w_dec.alu_op = alu_op_e'(w_opc);
        w_dec.is_cmp = 1'b1;
      end
      OPC_ADDI: begin
        w_dec.use_imm   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = {{(16-FIELD_W){instr[RT_LSB+FIELD_W-1]}}, instr[RT_LSB +: FIELD_W]};
      end
      OPC_NOP: ;
      default: w_dec.illegal = 1'b1;
    endcase
  end

  // flush wins over any same-edge acceptance
  assign w_push = in_valid & w_ready & ~flush;

  decode_skid #(.W($bits(dec_t))) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_push      (w_push),
    .i_data      (w_dec),
    .i_out_ready (out_ready),
    .o_valid     (out_valid),
    .o_data      (w_out),
    .o_ready     (w_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal_cnt <= '0;
    else if (w_push && w_dec.illegal && r_illegal_cnt != 8'hFF)
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
  end

  assign in_ready    = w_ready;
  assign alu_op      = w_out.alu_op;
  assign rd_addr     = w_out.rd;
  assign rs_addr     = w_out.rs;
  assign rt_addr     = w_out.rt;
  assign imm         = w_out.imm;
  assign use_imm     = w_out.use_imm;
  assign reg_write   = w_out.reg_write;
  assign is_cmp      = w_out.is_cmp;
  assign illegal     = w_out.illegal;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed-vector bench for alu_op_decoder; expectations follow DECODE_PARITY_OPS_EN.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, flush;
  logic [15:0] instr;
  logic        in_ready, out_valid, use_imm, reg_write, is_cmp, illegal;
  logic [3:0]  alu_op, rs_addr, rt_addr, rd_addr;
  logic [15:0] imm;
  logic [7:0]  illegal_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_op_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write), .is_cmp(is_cmp), .illegal(illegal), .flush(flush),
    .illegal_cnt(illegal_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single accept with out_ready=1, check decode one cycle later, then drain
  task automatic dec_vec(input string tag, input logic [15:0] ins, input logic [3:0] e_op,
                         input logic e_wr, input logic e_cmp, input logic e_uimm,
                         input logic e_ill, input logic [15:0] e_imm);
    in_valid = 1'b1;
    instr    = ins;
    step();
    in_valid = 1'b0;
    if (e_ill && exp_cnt < 255) exp_cnt++;
    chk({tag, ".vld"},  32'(out_valid), 32'd1);
    chk({tag, ".op"},   32'(alu_op),    32'(e_op));
    chk({tag, ".wr"},   32'(reg_write), 32'(e_wr));
    chk({tag, ".cmp"},  32'(is_cmp),    32'(e_cmp));
    chk({tag, ".uimm"}, 32'(use_imm),   32'(e_uimm));
    chk({tag, ".ill"},  32'(illegal),   32'(e_ill));
    chk({tag, ".imm"},  32'(imm),       32'(e_imm));
    chk({tag, ".rd"},   32'(rd_addr),   32'(ins[11:8]));
    chk({tag, ".rs"},   32'(rs_addr),   32'(ins[7:4]));
    chk({tag, ".rt"},   32'(rt_addr),   32'(ins[3:0]));
    chk({tag, ".cnt"},  32'(illegal_cnt), 32'(exp_cnt));
    step();
    chk({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = '0;
    step(); step(); step();
    chk("rst.in_ready", 32'(in_ready),    32'd0);
    chk("rst.vld",      32'(out_valid),   32'd0);
    chk("rst.cnt",      32'(illegal_cnt), 32'd0);
    chk("rst.op",       32'(alu_op),      32'd0);
    chk("rst.imm",      32'(imm),         32'd0);
    chk("rst.wr",       32'(reg_write),   32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready0", 32'(in_ready), 32'd0);
    step();
    chk("rel.in_ready1", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    dec_vec("sub",    16'h1123, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    dec_vec("addi_n", 16'h9F0E, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE);
    dec_vec("addi_p", 16'h9A57, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0007);
    dec_vec("add",    16'h0456, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    dec_vec("gte",    16'h4123, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    dec_vec("ltz",    16'h5000, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    dec_vec("ne",     16'h8321, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    dec_vec("nop",    16'hA123, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    dec_vec("ill_f",  16'hF123, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
`ifdef DECODE_PARITY_OPS_EN
    dec_vec("evup",   16'h2000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    dec_vec("evlo",   16'h3ABC, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
`else
    dec_vec("evup",   16'h2000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    dec_vec("evlo",   16'h3ABC, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
`endif

    // backpressure: three offers, two taken, drained in order
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 16'h0123; step();
    chk("bp.rdy_after1", 32'(in_ready), 32'd1);
    instr = 16'h1456; step();
    chk("bp.rdy_after2", 32'(in_ready), 32'd0);
    instr = 16'h7789; step();
    in_valid = 1'b0;
    chk("bp.rdy_after3", 32'(in_ready), 32'd0);
    chk("bp.hold_vld",   32'(out_valid), 32'd1);
    chk("bp.hold_op",    32'(alu_op),    32'd0);
    chk("bp.hold_rd",    32'(rd_addr),   32'd1);
    step();
    chk("bp.stable_op",  32'(alu_op),    32'd0);
    chk("bp.stable_rt",  32'(rt_addr),   32'd3);
    out_ready = 1'b1;
    step();
    chk("bp.2nd_vld",    32'(out_valid), 32'd1);
    chk("bp.2nd_op",     32'(alu_op),    32'd1);
    chk("bp.2nd_rd",     32'(rd_addr),   32'd4);
    chk("bp.2nd_rdy",    32'(in_ready),  32'd1);
    step();
    chk("bp.empty",      32'(out_valid), 32'd0);

    // flush with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 16'hC000; step();
    exp_cnt++;
    instr = 16'h0111; step();
    chk("fl1.full_rdy", 32'(in_ready), 32'd0);
    instr = 16'hD000; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1.vld", 32'(out_valid),   32'd0);
    chk("fl1.rdy", 32'(in_ready),    32'd1);
    chk("fl1.cnt", 32'(illegal_cnt), 32'(exp_cnt));
    // flush beats an acceptance that would otherwise have been taken
    in_valid = 1'b1; instr = 16'h0222; step();
    instr = 16'hE000; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2.vld", 32'(out_valid),   32'd0);
    chk("fl2.cnt", 32'(illegal_cnt), 32'(exp_cnt));
    step();
    chk("fl2.vld_later", 32'(out_valid), 32'd0);

    // counter saturation
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 16'hC000;
    for (int i = 0; i < 300; i++) begin
      step();
      if (exp_cnt < 255) exp_cnt++;
      chk("sat.ill", 32'(illegal),     32'd1);
      chk("sat.cnt", 32'(illegal_cnt), 32'(exp_cnt));
    end
    in_valid = 1'b0;
    step();
    chk("sat.final", 32'(illegal_cnt), 32'd255);

    // reset asserted mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 16'h1111; step();
    instr = 16'hC000; step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.vld", 32'(out_valid),   32'd0);
    chk("mrst.rdy", 32'(in_ready),    32'd0);
    chk("mrst.cnt", 32'(illegal_cnt), 32'd0);
    chk("mrst.op",  32'(alu_op),      32'd0);
    chk("mrst.rd",  32'(rd_addr),     32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst.rdy_back", 32'(in_ready),  32'd1);
    chk("mrst.vld_back", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
